// File: rtl/nvram_upload_ctrl_if.sv
// Bundle between data_io (ioctl upload side), the game CPU write strobe and the
// shared CMOS RAM read port. The controller uses the slave view.
interface nvram_upload_ctrl_if #(
  parameter int ADDR_W = 11
);
  logic              ioctl_upload;
  logic [7:0]        ioctl_index;
  logic              ioctl_rd;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_din_valid;
  logic              upl_busy;
  logic              overrun;
  logic              cpu_cmos_we;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic [7:0]        ram_q;
  logic              dirty;

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, cpu_cmos_we, ram_q,
    output ioctl_din, ioctl_din_valid, upl_busy, overrun, ram_addr, ram_rd, dirty
  );

  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, cpu_cmos_we, ram_q,
    input  ioctl_din, ioctl_din_valid, upl_busy, overrun, ram_addr, ram_rd, dirty
  );
endinterface

// File: rtl/nvram_upload_ctrl.sv
// NVRAM upload (read-back) controller: answers data_io byte requests from the
// shared CMOS RAM port, yielding to CPU writes, and tracks the NVRAM dirty flag.
module nvram_upload_ctrl #(
  parameter int         ADDR_W      = 11,
  parameter int         NVRAM_SIZE  = 2048,
  parameter logic [7:0] NVRAM_INDEX = 8'hFF,
  parameter logic [7:0] FILL_BYTE   = 8'hFF
) (
  input  logic               clk_sys,
  input  logic               reset,
  nvram_upload_ctrl_if.slave bus
);

  localparam int               CNT_W     = $clog2(NVRAM_SIZE + 1);
  localparam logic [24:0]      SIZE_ADDR = 25'(NVRAM_SIZE);
  localparam logic [CNT_W-1:0] SIZE_CNT  = CNT_W'(NVRAM_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_ISSUE,
    S_CAPTURE,
    S_REPLY
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        din_q, din_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              in_range_q, in_range_d;
  logic              overrun_q, overrun_d;
  logic              dirty_q, dirty_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_seen_q, write_seen_d;
  logic              act_q;

  logic act, act_rise, act_fall, busy;

  assign act      = bus.ioctl_upload & (bus.ioctl_index == NVRAM_INDEX);
  assign act_rise = act & ~act_q;
  assign act_fall = ~act & act_q;
  assign busy     = (state_q == S_ISSUE) | (state_q == S_CAPTURE) | (state_q == S_REPLY);

  // NOTE: every _d defaults to its _q before the case so no path leaves a latch.
  always_comb begin
    state_d      = state_q;
    din_d        = din_q;
    ram_addr_d   = ram_addr_q;
    in_range_d   = in_range_q;
    overrun_d    = overrun_q;
    dirty_d      = dirty_q;
    cnt_d        = cnt_q;
    write_seen_d = write_seen_q;

    case (state_q)
      S_IDLE: begin
        if (act_rise) begin
          state_d      = S_ARMED;
          overrun_d    = 1'b0;
          cnt_d        = '0;
          write_seen_d = 1'b0;
        end
      end
      S_ARMED: begin
        if (!act) begin
          state_d = S_IDLE;
        end else if (bus.ioctl_rd) begin
          if (bus.ioctl_addr >= SIZE_ADDR) begin
            state_d    = S_REPLY;
            din_d      = FILL_BYTE;
            in_range_d = 1'b0;
          end else begin
            state_d    = S_ISSUE;
            ram_addr_d = bus.ioctl_addr[ADDR_W-1:0];
            in_range_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (!bus.cpu_cmos_we) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        din_d   = bus.ram_q;
        state_d = S_REPLY;
      end
      S_REPLY: begin
        if (in_range_q && (cnt_q != SIZE_CNT)) cnt_d = cnt_q + CNT_W'(1);
        state_d = act ? S_ARMED : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (busy && bus.ioctl_rd) overrun_d = 1'b1;

    // A save is only complete if every byte went out with no CPU write in between;
    // a CPU write always re-marks the NVRAM, even on the clearing edge itself.
    if (act && bus.cpu_cmos_we) write_seen_d = 1'b1;
    if (act_fall && (cnt_q == SIZE_CNT) && !write_seen_q) dirty_d = 1'b0;
    if (bus.cpu_cmos_we) dirty_d = 1'b1;
  end

  // NOTE: state registers take non-blocking assignments only; the comb block above uses blocking.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      din_q        <= 8'h00;
      ram_addr_q   <= '0;
      in_range_q   <= 1'b0;
      overrun_q    <= 1'b0;
      dirty_q      <= 1'b0;
      cnt_q        <= '0;
      write_seen_q <= 1'b0;
      act_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      din_q        <= din_d;
      ram_addr_q   <= ram_addr_d;
      in_range_q   <= in_range_d;
      overrun_q    <= overrun_d;
      dirty_q      <= dirty_d;
      cnt_q        <= cnt_d;
      write_seen_q <= write_seen_d;
      act_q        <= act;
    end
  end

  assign bus.ioctl_din       = din_q;
  assign bus.ioctl_din_valid = (state_q == S_REPLY);
  assign bus.upl_busy        = busy;
  assign bus.overrun         = overrun_q;
  assign bus.ram_addr        = ram_addr_q;
  // The CPU owns the port whenever it writes, so the read is gated combinationally.
  assign bus.ram_rd          = (state_q == S_ISSUE) & ~bus.cpu_cmos_we;
  assign bus.dirty           = dirty_q;

endmodule

// File: tb/tb_nvram_upload_ctrl.sv
// Self-checking bench for nvram_upload_ctrl: random upload sessions against a
// transaction-level model of reply latency, data, overrun and dirty tracking.
module tb_nvram_upload_ctrl;

  localparam int ADDR_W     = 11;
  localparam int NVRAM_SIZE = 2048;

  logic clk_sys = 1'b0;
  logic reset   = 1'b0;

  always #5 clk_sys = ~clk_sys;

  nvram_upload_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  nvram_upload_ctrl #(
    .ADDR_W     (ADDR_W),
    .NVRAM_SIZE (NVRAM_SIZE),
    .NVRAM_INDEX(8'hFF),
    .FILL_BYTE  (8'hFF)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  // Shared CMOS RAM: CPU writes and controller reads through one port.
  logic [7:0]        mem [NVRAM_SIZE];
  logic [ADDR_W-1:0] cpu_waddr = '0;
  logic [7:0]        cpu_wdata = '0;

  always @(posedge clk_sys) begin
    if (bus.cpu_cmos_we) mem[cpu_waddr] <= cpu_wdata;
    if (bus.ram_rd) bus.ram_q <= mem[bus.ram_addr];
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit dirty_m = 1'b0;
  bit ws_m    = 1'b0;
  bit ovr_m   = 1'b0;
  int cnt_m   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic bit act_now();
    return bus.ioctl_upload && (bus.ioctl_index == 8'hFF);
  endfunction

  task automatic cpu_we_set(input bit we, input logic [ADDR_W-1:0] avoid);
    bus.cpu_cmos_we = we;
    if (we) begin
      cpu_waddr = ADDR_W'($urandom_range(0, NVRAM_SIZE - 1));
      if (cpu_waddr == avoid) cpu_waddr = cpu_waddr ^ ADDR_W'(1);
      cpu_wdata = 8'($urandom);
      dirty_m   = 1'b1;
      if (act_now()) ws_m = 1'b1;
    end
  endtask

  task automatic model_fall();
    if (cnt_m >= NVRAM_SIZE && !ws_m) dirty_m = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_din"},      bus.ioctl_din, 8'h00);
    check({tag, "_valid"},    bus.ioctl_din_valid, 1'b0);
    check({tag, "_busy"},     bus.upl_busy, 1'b0);
    check({tag, "_overrun"},  bus.overrun, 1'b0);
    check({tag, "_ram_rd"},   bus.ram_rd, 1'b0);
    check({tag, "_ram_addr"}, bus.ram_addr, '0);
    check({tag, "_dirty"},    bus.dirty, 1'b0);
  endtask

  // One byte request issued in the current cycle (N); stall = CPU write cycles from N+1.
  task automatic do_req(input logic [24:0] addr, input int stall, input bit dbl, input int drop_j);
    bit         oor;
    int         exp_lat;
    logic [7:0] exp_d;
    int         pulses;
    int         first;
    oor     = (addr >= 25'(NVRAM_SIZE));
    exp_lat = oor ? 1 : 3 + stall;
    exp_d   = oor ? 8'hFF : mem[addr[ADDR_W-1:0]];
    pulses  = 0;
    first   = 0;
    bus.ioctl_rd   = 1'b1;
    bus.ioctl_addr = addr;
    for (int j = 1; j <= 40; j++) begin
      step();
      bus.ioctl_rd = dbl && (j == 1);
      if (j == drop_j) begin
        bus.ioctl_upload = 1'b0;
        model_fall();
      end
      cpu_we_set(j <= stall, addr[ADDR_W-1:0]);
      @(negedge clk_sys);
      if (bus.ioctl_din_valid) begin
        pulses++;
        if (first == 0) begin
          first = j;
          check("rd_data", bus.ioctl_din, exp_d);
        end
      end
      check("busy", bus.upl_busy, (j <= exp_lat) ? 1 : 0);
      check("ram_rd", bus.ram_rd, (!oor && j == stall + 1) ? 1 : 0);
      if (!oor && j <= stall + 2) check("ram_addr", bus.ram_addr, addr[ADDR_W-1:0]);
      if (j >= exp_lat + 1) break;
    end
    check("latency", first, exp_lat);
    check("pulses", pulses, 1);
    if (dbl) ovr_m = 1'b1;
    if (!oor && cnt_m < NVRAM_SIZE) cnt_m++;
    step();
    bus.cpu_cmos_we = 1'b0;
  endtask

  task automatic start_session();
    bus.ioctl_index  = 8'hFF;
    bus.ioctl_upload = 1'b1;
    cnt_m = 0;
    ws_m  = 1'b0;
    ovr_m = 1'b0;
    step();
    step();
    check("ovr_cleared", bus.overrun, ovr_m);
  endtask

  task automatic end_session(input bit via_index, input bit we_at_fall);
    if (via_index) bus.ioctl_index = 8'h3C;
    else           bus.ioctl_upload = 1'b0;
    model_fall();
    cpu_we_set(we_at_fall, '0);
    step();
    cpu_we_set(1'b0, '0);
    step();
    @(negedge clk_sys);
    check("dirty_end", bus.dirty, dirty_m);
    check("end_busy", bus.upl_busy, 1'b0);
    step();
  endtask

  task automatic run_upload(input int n_in, input int n_oor, input bit stalls_ok);
    logic [24:0] q[$];
    for (int i = 0; i < n_in; i++) q.push_back(25'($urandom_range(0, NVRAM_SIZE - 1)));
    for (int i = 0; i < n_oor; i++)
      q.insert($urandom_range(0, q.size()), 25'($urandom_range(NVRAM_SIZE, 32'h01FF_FFFF)));
    foreach (q[i]) do_req(q[i], stalls_ok ? int'($urandom_range(0, 2)) : 0, 1'b0, 0);
  endtask

  task automatic set_dirty_idle();
    cpu_we_set(1'b1, '0);
    step();
    cpu_we_set(1'b0, '0);
    @(negedge clk_sys);
    check("dirty_set", bus.dirty, dirty_m);
    step();
  endtask

  initial begin
    int pulses;
    bus.ioctl_upload = 1'b0;
    bus.ioctl_index  = 8'h00;
    bus.ioctl_rd     = 1'b0;
    bus.ioctl_addr   = '0;
    bus.cpu_cmos_we  = 1'b0;
    #2 reset = 1'b1;

    // Preload the RAM through the CPU port while the controller is held in reset.
    for (int i = 0; i < NVRAM_SIZE; i++) begin
      step();
      cpu_waddr       = ADDR_W'(i);
      cpu_wdata       = (i == 'h123) ? 8'hA5 : 8'($urandom);
      bus.cpu_cmos_we = 1'b1;
    end
    step();
    bus.cpu_cmos_we = 1'b0;
    step();
    @(negedge clk_sys);
    check_reset_outputs("reset");
    step();
    reset = 1'b0;
    step();

    // Request with another index active is ignored.
    bus.ioctl_upload = 1'b1;
    bus.ioctl_index  = 8'h01;
    step();
    bus.ioctl_rd   = 1'b1;
    bus.ioctl_addr = 25'h010;
    step();
    bus.ioctl_rd = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_sys);
      if (bus.ioctl_din_valid) pulses++;
      step();
    end
    check("idle_rd_pulses", pulses, 0);
    check("idle_rd_overrun", bus.overrun, 1'b0);
    bus.ioctl_upload = 1'b0;
    step();

    set_dirty_idle();

    // Directed requests
    start_session();
    do_req(25'h123, 0, 1'b0, 0);
    check("basic_a5", bus.ioctl_din, 8'hA5);
    do_req(25'($urandom_range(0, NVRAM_SIZE - 1)), 5, 1'b0, 0);
    do_req(25'h800, 0, 1'b0, 0);
    do_req(25'h1FF_FFFF, 0, 1'b0, 0);
    do_req(25'h7FF, 0, 1'b0, 0);
    do_req(25'h055, 0, 1'b1, 0);
    check("ovr_set", bus.overrun, ovr_m);
    do_req(25'h0C00, 0, 1'b1, 0);
    check("ovr_hold", bus.overrun, ovr_m);

    // Reset during a stalled read
    bus.ioctl_rd   = 1'b1;
    bus.ioctl_addr = 25'h2AA;
    step();
    bus.ioctl_rd = 1'b0;
    cpu_we_set(1'b1, 11'h2AA);
    step();
    step();
    @(negedge clk_sys);
    check("stall_busy", bus.upl_busy, 1'b1);
    check("stall_ram_rd", bus.ram_rd, 1'b0);
    #2 reset = 1'b1;
    #1 check_reset_outputs("mid_reset");
    bus.cpu_cmos_we  = 1'b0;
    bus.ioctl_upload = 1'b0;
    dirty_m = 1'b0;
    ws_m    = 1'b0;
    ovr_m   = 1'b0;
    cnt_m   = 0;
    step();
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_sys);
      if (bus.ioctl_din_valid) pulses++;
      step();
    end
    check("post_reset_pulses", pulses, 0);

    // Clean full upload with filler requests mixed in: dirty clears.
    set_dirty_idle();
    start_session();
    run_upload(NVRAM_SIZE, 16, 1'b0);
    end_session(1'b0, 1'b0);

    // CPU writes during the upload (stalls) plus an overrun: dirty stays set.
    set_dirty_idle();
    start_session();
    do_req(25'($urandom_range(0, NVRAM_SIZE - 1)), 0, 1'b1, 0);
    run_upload(NVRAM_SIZE, 8, 1'b1);
    end_session(1'b1, 1'b0);

    // Aborted upload: act drops while the 100th request is in flight.
    start_session();
    run_upload(99, 0, 1'b0);
    do_req(25'($urandom_range(0, NVRAM_SIZE - 1)), 0, 1'b0, 1);
    @(negedge clk_sys);
    check("dirty_abort", bus.dirty, dirty_m);
    step();

    // One byte short, filler replies must not make up the difference.
    start_session();
    run_upload(NVRAM_SIZE - 1, 30, 1'b0);
    end_session(1'b0, 1'b0);

    // Counter restarts on the next session, so a clean full upload clears again.
    start_session();
    run_upload(NVRAM_SIZE, 0, 1'b0);
    end_session(1'b1, 1'b0);

    // CPU write on the clearing edge wins.
    set_dirty_idle();
    start_session();
    run_upload(NVRAM_SIZE, 0, 1'b0);
    end_session(1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nvram_upload_ctrl.md
Name: nvram_upload_ctrl

Overview:
- Serves the upload (read-back) direction of the CMOS/NVRAM save path.
- When the loader starts an upload on the NVRAM index, the block answers each byte request from the SPI data_io layer by reading the game's CMOS RAM through a shared single-port RAM port. The game CPU always has priority on that port.
- Tracks a dirty flag that marks when the game has modified NVRAM since the last complete save.
- Sits between data_io (ioctl_upload/ioctl_din) and the game core's CMOS RAM. It is the reader counterpart of the cmos_wr download path.

Parameters:
ADDR_W, 11, CMOS RAM address width
NVRAM_SIZE, 2048, number of valid NVRAM bytes; requests at or above this address return filler
NVRAM_INDEX, 8'hFF, ioctl_index value that selects the NVRAM upload
FILL_BYTE, 8'hFF, data returned for out-of-range requests

Ports:
clk_sys  in  1  system clock (40 MHz)
reset  in  1  asynchronous, active-high
ioctl_upload  in  1  upload in progress (from data_io)
ioctl_index  in  8  upload target index
ioctl_rd  in  1  one-cycle byte request strobe
ioctl_addr  in  25  byte address of the request, valid with ioctl_rd
ioctl_din  out  8  returned byte
ioctl_din_valid  out  1  one-cycle pulse, ioctl_din valid
upl_busy  out  1  a request is being serviced
overrun  out  1  sticky: a request arrived while busy
cpu_cmos_we  in  1  game CPU write to CMOS RAM this cycle (has port priority)
ram_addr  out  ADDR_W  read address to the shared CMOS RAM port
ram_rd  out  1  read enable to the shared port
ram_q  in  8  RAM read data, valid the cycle after ram_rd
dirty  out  1  NVRAM changed since the last complete save

Behaviour:
- Reset values (async, while reset=1): state IDLE, ioctl_din=8'h00, ioctl_din_valid=0, upl_busy=0, overrun=0, ram_rd=0, ram_addr=0, dirty=0, byte counter=0, write_seen=0.
- Active condition: act = ioctl_upload & (ioctl_index==NVRAM_INDEX).
- States:
  - IDLE: when act rises, go to ARMED; clear overrun, the byte counter and write_seen.
  - ARMED: on ioctl_rd, latch ioctl_addr.
    - If addr >= NVRAM_SIZE, go to REPLY with ioctl_din=FILL_BYTE; the counter is not incremented.
    - Otherwise go to ISSUE with ram_addr=addr[ADDR_W-1:0].
  - ISSUE: ram_rd = ~cpu_cmos_we (combinational gate).
    - If cpu_cmos_we=1, stay (stall, unbounded).
    - Else go to CAPTURE.
  - CAPTURE: sample ram_q into ioctl_din, go to REPLY.
  - REPLY: ioctl_din_valid=1 for exactly this cycle. Increment the counter, saturating at NVRAM_SIZE, for in-range requests only. Return to ARMED, or to IDLE if act=0.
- upl_busy is high in ISSUE, CAPTURE and REPLY.
- Latency without contention: ioctl_rd at cycle N, ram_rd at N+1, valid at N+3. Out-of-range request: valid at N+1.
- ioctl_rd while upl_busy is dropped, no response, and sets overrun=1. overrun holds until the next act rise or reset.
- ioctl_rd in IDLE is ignored without setting overrun.
- If act falls mid-request, the in-flight request completes (valid still pulses), then the block goes to IDLE.
- Dirty tracking:
  - Any cpu_cmos_we sets dirty=1.
  - A cpu_cmos_we while act=1 also sets write_seen=1.
  - On the falling edge of act: if counter==NVRAM_SIZE and write_seen=0, clear dirty. Otherwise leave dirty unchanged.
  - If cpu_cmos_we and the clearing edge occur in the same cycle, dirty=1 wins.
- Repeated addresses count again. Completeness means NVRAM_SIZE in-range replies, not unique addresses.
- ram_addr is stable from entry to ISSUE through CAPTURE.

Test Plan:
- Reset mid-ISSUE: assert reset during a stalled read -> all outputs return to their reset values immediately; with no ioctl_rd after release, no valid pulse occurs.
- Basic read: RAM[0x123]=8'hA5, act=1, ioctl_rd with addr 0x123 at N -> ram_rd=1 and ram_addr=0x123 at N+1; ioctl_din=8'hA5 and valid=1 at N+3 only.
- Contention: cpu_cmos_we held high for 5 cycles starting at N+1 -> ram_rd stays 0 throughout; valid at N+8 with correct data.
- Out-of-range: ioctl_rd with addr 0x800 -> valid at N+1 with ioctl_din=8'hFF; counter unchanged.
- Overrun: second ioctl_rd at N+1 -> exactly one valid pulse, overrun=1; overrun cleared on the next upload start.
- Dirty lifecycle:
  - CPU write sets dirty=1; full 2048-byte upload, then act falls -> dirty=0.
  - Repeat with a CPU write during the upload -> dirty stays 1.
  - Repeat with an upload aborted after 100 bytes -> dirty stays 1.
